// File: rtl/imem_wb_pkg.sv
// rtl/imem_wb_pkg.sv - shared constants, FSM states and helpers for the imem Wishbone loader
//
// Purpose: register-map offsets, CTRL bit positions, loader FSM state type and
// a saturating counter helper used by imem_wb_loader.
// Ports: none (package).

package imem_wb_pkg;

  localparam logic [11:0] OFF_CTRL = 12'h800;
  localparam logic [11:0] OFF_STAT = 12'h804;
  localparam logic [11:0] SRAM_TOP = 12'h7FC;

  localparam int RUN_BIT = 0;
  localparam int ERR_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWR,
    ST_SRD,
    ST_ACK
  } state_t;

  // STATUS word counter: sticks at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/imem_wb_loader_if.sv
// rtl/imem_wb_loader_if.sv - Wishbone classic slave bus bundle for the imem loader
//
// Purpose: groups the wbs_* signals; _i/_o suffixes are from the slave's view.
// Ports (signals):
//   wbs_cyc_i, wbs_stb_i, wbs_we_i  master -> slave  cycle, strobe, write enable
//   wbs_sel_i[3:0]                  master -> slave  byte selects
//   wbs_adr_i[31:0]                 master -> slave  byte address
//   wbs_dat_i[31:0]                 master -> slave  write data
//   wbs_dat_o[31:0]                 slave -> master  read data
//   wbs_ack_o                       slave -> master  one-cycle acknowledge

interface imem_wb_loader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/imem_wb_loader.sv
// rtl/imem_wb_loader.sv - Wishbone slave owning imem port 0 plus core run/halt control
//
// Purpose: loads/reads the 512x32 instruction SRAM word by word over Wishbone,
// and holds the core in reset until software sets CTRL.RUN.
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wbs                    Wishbone classic slave (imem_wb_loader_if.slave)
//   sram_csb0/web0/wmask0/addr0/din0  SRAM port 0 controls (registered)
//   sram_dout0             SRAM port 0 read data
//   cpu_rst_o              core reset, registered copy of ~RUN

module imem_wb_loader
  import imem_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          AW        = 9,
  parameter int          RD_LAT    = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  imem_wb_loader_if.slave     wbs,
  output logic                sram_csb0,
  output logic                sram_web0,
  output logic [3:0]          sram_wmask0,
  output logic [AW-1:0]       sram_addr0,
  output logic [31:0]         sram_din0,
  input  logic [31:0]         sram_dout0,
  output logic                cpu_rst_o
);

  localparam logic [3:0] LAT_LAST = 4'(RD_LAT);

  state_t        state_q;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic          csb_q;
  logic          web_q;
  logic [3:0]    wmask_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   din_q;
  logic          run_q;
  logic          err_q;
  logic          cpu_rst_q;
  logic [15:0]   count_q;
  logic [3:0]    lat_q;

  // Request decode, only consulted in IDLE.
  logic [11:0] off_d;
  logic        hit_d;
  logic        is_sram_d;
  logic        is_ctrl_d;
  logic        is_stat_d;
  logic [31:0] reg_rdata_d;

  assign off_d     = wbs.wbs_adr_i[11:0];
  assign hit_d     = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                     (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign is_sram_d = (off_d[11:2] <= SRAM_TOP[11:2]);
  assign is_ctrl_d = (off_d[11:2] == OFF_CTRL[11:2]);
  assign is_stat_d = (off_d[11:2] == OFF_STAT[11:2]);

  always_comb begin
    reg_rdata_d = 32'h0;
    if (is_ctrl_d) begin
      reg_rdata_d[RUN_BIT] = run_q;
      reg_rdata_d[ERR_BIT] = err_q;
    end else if (is_stat_d) begin
      reg_rdata_d = {err_q, 15'h0, count_q};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      dat_q     <= 32'h0;
      csb_q     <= 1'b1;
      web_q     <= 1'b1;
      wmask_q   <= 4'h0;
      addr_q    <= '0;
      din_q     <= 32'h0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      count_q   <= 16'h0;
      lat_q     <= 4'h0;
    end else begin
      cpu_rst_q <= ~run_q;

      case (state_q)
        ST_IDLE: begin
          if (hit_d) begin
            if (is_sram_d) begin
              if (run_q) begin
                // Core owns the instruction stream: refuse SRAM access.
                err_q   <= 1'b1;
                dat_q   <= 32'h0;
                ack_q   <= 1'b1;
                state_q <= ST_ACK;
              end else begin
                csb_q   <= 1'b0;
                web_q   <= ~wbs.wbs_we_i;
                addr_q  <= wbs.wbs_adr_i[AW+1:2];
                lat_q   <= 4'h0;
                if (wbs.wbs_we_i) begin
                  wmask_q <= wbs.wbs_sel_i;
                  din_q   <= wbs.wbs_dat_i;
                  state_q <= ST_SWR;
                end else begin
                  state_q <= ST_SRD;
                end
              end
            end else begin
              dat_q <= wbs.wbs_we_i ? 32'h0 : reg_rdata_d;
              if (wbs.wbs_we_i && is_ctrl_d) begin
                if (wbs.wbs_sel_i[0]) begin
                  run_q <= wbs.wbs_dat_i[RUN_BIT];
                end
                if (wbs.wbs_sel_i[3] && wbs.wbs_dat_i[ERR_BIT]) begin
                  err_q <= 1'b0;
                end
              end
              ack_q   <= 1'b1;
              state_q <= ST_ACK;
            end
          end
        end

        ST_SWR: begin
          csb_q <= 1'b1;
          web_q <= 1'b1;
          if (|wmask_q) begin
            count_q <= sat_inc16(count_q);
          end
          dat_q   <= 32'h0;
          ack_q   <= 1'b1;
          state_q <= ST_ACK;
        end

        ST_SRD: begin
          // lat_q counts edges after the one that sampled csb0 low.
          csb_q <= 1'b1;
          if (lat_q == LAT_LAST) begin
            dat_q   <= sram_dout0;
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end else begin
            lat_q <= lat_q + 4'd1;
          end
        end

        ST_ACK: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign sram_csb0     = csb_q;
  assign sram_web0     = web_q;
  assign sram_wmask0   = wmask_q;
  assign sram_addr0    = addr_q;
  assign sram_din0     = din_q;
  assign cpu_rst_o     = cpu_rst_q;

endmodule

// File: doc/imem_wb_loader.md
Name: imem_wb_loader

Overview:
- Wishbone classic slave that owns the read/write port (port 0) of the 512x32 instruction SRAM.
- Lets the management SoC load a program word by word and read it back.
- Controls run/halt of the SLRV core through a control register, so the core fetches from SRAM port 1 only after loading completes.
- Sits in user_project_wrapper between the wbs_* bus, imem port 0 and the core's reset input.

Parameters:
- BASE_ADDR, 32'h3000_0000, window base; decode uses adr[31:12] == BASE_ADDR[31:12].
- AW, 9, SRAM word-address width (512 words).
- RD_LAT, 1, SRAM clocks from the read-enable edge to valid dout0.

Ports:
- wb_clk_i  in  1  single clock for the block, SRAM clk0 and the core.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- sram_csb0  out  1  port-0 chip select, active low.
- sram_web0  out  1  port-0 write enable, active low.
- sram_wmask0  out  4  byte write mask.
- sram_addr0  out  AW  word address.
- sram_din0  out  32  write data.
- sram_dout0  in  32  read data.
- cpu_rst_o  out  1  holds the core in reset while 1.

Behaviour:
- Memory map, offsets from BASE:
  - 0x000–0x7FC: SRAM words; word address = adr[10:2].
  - 0x800: CTRL. bit0 RUN (R/W). Bit31 is write-1-to-clear for ERR.
  - 0x804: STATUS (RO). [15:0] count of words written, saturating at 0xFFFF. [31] ERR, sticky.
  - 0x808–0xFFF: ack, read 0, writes ignored.
  - Outside the window: never acked; the FSM stays in IDLE.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, RUN=0, cpu_rst_o=1, count=0, ERR=0.
- cpu_rst_o = ~RUN, registered. It updates the cycle after the CTRL write is acked.
- FSM states: IDLE, SWR, SRD, ACK.
- IDLE:
  - On cyc&stb and a window match, register the request.
  - SRAM window and RUN=0:
    - write → SWR. csb0=0, web0=0, wmask0=sel, addr0, din0 driven for exactly one cycle.
    - read → SRD. csb0=0, web0=1 for one cycle.
  - SRAM window and RUN=1: no SRAM access, set ERR, go to ACK with dat_o=0.
  - Register or unmapped offset: go to ACK with dat_o loaded.
  - CTRL writes honour sel[0] for RUN and sel[3] for the ERR clear.
- SWR: csb0 returns to 1. Increment count if sel!=0. Go to ACK.
- SRD:
  - Wait RD_LAT cycles after the enable edge.
  - Capture sram_dout0 into dat_o.
  - Go to ACK.
- ACK:
  - wbs_ack_o=1 for exactly one cycle, then IDLE.
  - A new request is not accepted in the ACK cycle.
  - Minimum spacing between acks is 2 cycles.
- Latency from the request cycle to ack:
  - Register or error access: 1 cycle.
  - SRAM write: 2 cycles.
  - SRAM read: 2+RD_LAT cycles.
- sram_csb0 is never low for more than one consecutive cycle per transaction. It is never low while RUN=1.
- If cyc drops mid-transaction, the SRAM operation still completes and ack is still pulsed; the master ignores it.
- Simultaneous events:
  - A CTRL write with RUN=1 and bit31=1 clears ERR and sets RUN.
  - If the ERR set and the ERR clear occur in the same cycle, set wins.
- wb_rst_i asserted mid-transaction: on the next edge all outputs take their reset values. No ack is issued and any pending SRAM write is abandoned; csb0 goes to 1 at that edge.

Decomposition:
- Shared package imem_wb_pkg:
  - Offset constants: OFF_CTRL=12'h800, OFF_STAT=12'h804, SRAM_TOP=12'h7FC.
  - FSM state enum.
  - CTRL bit indices RUN_BIT=0 and ERR_BIT=31.
- No sub-module; a single FSM plus register file.

Test Plan:
- Reset → read STATUS = 0x0000_0000, read CTRL = 0; cpu_rst_o=1, sram_csb0=1 throughout.
- Write 0xDEADBEEF to BASE+0x010 with sel=4'hF:
  - csb0=0, web0=0, addr0=4, wmask0=F for one cycle; ack 2 cycles after request.
  - Read-back returns 0xDEADBEEF, ack at 2+RD_LAT cycles.
  - STATUS count = 1.
- Write 0x11223344 to BASE+0x010 with sel=4'h2 → wmask0=4'b0010; read-back returns 0xDEAD33EF.
- Write CTRL=1:
  - cpu_rst_o falls the cycle after ack.
  - A subsequent write to BASE+0x000 produces no csb0 pulse but is acked; STATUS[31]=1.
  - Write CTRL=0x8000_0001 → ERR=0, RUN stays 1.
- Access to BASE+0x1000 and to 0x2000_0000 → no ack for 16 cycles, csb0 stays 1.
- Assert wb_rst_i in the SRD cycle:
  - No ack; csb0=1 at the next edge; RUN=0 and count=0.
  - The next write transaction completes normally.
